dmem_bytewise: RTL and testbench

- Parametrised data memory for the single-cycle/multi-cycle CPU datapath; successor to the fixed 32x32 word-only data memory.
- Adds byte/halfword stores with lane merging, sign/zero-extended sub-word loads and a registered read with a valid strobe.
- Adds alignment and range error flags, plus a hardware zero-fill sequence after reset. While the fill runs, `busy` stalls the CPU.

---
 rtl/dmem_bytewise_if.sv | 27 ++
 rtl/dmem_bytewise.sv | 137 +++++++++++++
 tb/tb_dmem_bytewise.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_bytewise_if.sv
// Data-memory bus between the CPU datapath and dmem_bytewise.
// The master drives the request fields; the slave returns load data, strobes and status.
interface dmem_bytewise_if #(
    parameter int ADDR_W = 11
) ();
    logic              ena;
    logic              dmw;
    logic              dmr;
    logic [2:0]        dm_type;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              rdata_valid;
    logic              busy;
    logic              err_align;
    logic              err_range;

    modport master (
        output ena, dmw, dmr, dm_type, dm_addr, dm_wdata,
        input  dm_rdata, rdata_valid, busy, err_align, err_range
    );

    modport slave (
        input  ena, dmw, dmr, dm_type, dm_addr, dm_wdata,
        output dm_rdata, rdata_valid, busy, err_align, err_range
    );
endinterface

// File: rtl/dmem_bytewise.sv
// Byte-addressable data memory with sub-word stores and loads, a registered read port,
// alignment/range error pulses and a zero-fill of every word after reset.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_FILL | zero-fill word[r_cnt] each cycle; busy high, requests ignored
//   ST_IDLE | accept one read and/or write request per cycle
module dmem_bytewise #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_bytewise_if.slave bus
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    localparam logic [2:0] T_WORD = 3'b000;
    localparam logic [2:0] T_HS   = 3'b001;
    localparam logic [2:0] T_HU   = 3'b010;
    localparam logic [2:0] T_BS   = 3'b011;
    localparam logic [2:0] T_BU   = 3'b100;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [MEM_AW-1:0] r_cnt;
    logic [31:0]       r_rdata;
    logic              r_rvalid;
    logic              r_err_align;
    logic              r_err_range;

    logic [ADDR_W-3:0] w_idx;
    logic [MEM_AW-1:0] w_midx;
    logic [1:0]        w_lane;
    logic              w_req;
    logic              w_rd;
    logic              w_wr_ok;
    logic              w_err_align;
    logic              w_err_range;
    logic [3:0]        w_be;
    logic [31:0]       w_wrep;
    logic [31:0]       w_word;
    logic [15:0]       w_half;
    logic [7:0]        w_byte;
    logic [31:0]       w_load;

    assign w_idx   = bus.dm_addr[ADDR_W-1:2];
    assign w_midx  = w_idx[MEM_AW-1:0];
    assign w_lane  = bus.dm_addr[1:0];
    assign w_req   = bus.ena && (bus.dmr || bus.dmw) && (r_state == ST_IDLE);
    assign w_rd    = w_req && bus.dmr;
    assign w_wr_ok = w_req && bus.dmw && !w_err_align && !w_err_range;
    assign w_err_range = (32'(w_idx) >= DEPTH);

    // Out-of-range indices never reach the array, so the truncated index is only used when valid.
    assign w_word = w_err_range ? '0 : r_mem[w_midx];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
    assign w_byte = w_word[8*w_lane +: 8];

    always_comb begin
        w_err_align = 1'b0;
        w_be        = 4'b0000;
        w_wrep      = bus.dm_wdata;
        w_load      = '0;
        case (bus.dm_type)
            T_WORD: begin
                w_err_align = (w_lane != 2'b00);
                w_be        = 4'b1111;
                w_load      = w_word;
            end
            T_HS, T_HU: begin
                w_err_align = w_lane[0];
                w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wrep      = {2{bus.dm_wdata[15:0]}};
                w_load      = (bus.dm_type == T_HS) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            end
            T_BS, T_BU: begin
                w_be        = 4'b0001 << w_lane;
                w_wrep      = {4{bus.dm_wdata[7:0]}};
                w_load      = (bus.dm_type == T_BS) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            end
            default: w_err_align = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
        end else if (r_state == ST_FILL) begin
            if (r_cnt == MEM_AW'(DEPTH - 1)) begin
                r_state <= ST_IDLE;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Array has no reset; the fill sequence is what clears it.
    always_ff @(posedge clk) begin
        if (r_state == ST_FILL) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_midx][8*i +: 8] <= w_wrep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_err_align <= 1'b0;
            r_err_range <= 1'b0;
        end else begin
            r_rvalid    <= w_rd;
            r_err_align <= w_req && w_err_align;
            r_err_range <= w_req && w_err_range;
            if (w_rd) begin
                r_rdata <= (w_err_align || w_err_range) ? '0 : w_load;
            end
        end
    end

    assign bus.dm_rdata    = r_rdata;
    assign bus.rdata_valid = r_rvalid;
    assign bus.busy        = (r_state == ST_FILL);
    assign bus.err_align   = r_err_align;
    assign bus.err_range   = r_err_range;
endmodule

// File: tb/tb_dmem_bytewise.sv
// Directed bench for dmem_bytewise: fill timing, sub-word stores/loads, errors,
// read-before-write and reset during fill.
module tb_dmem_bytewise;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cyc;

    dmem_bytewise_if #(.ADDR_W(11)) bus ();

    dmem_bytewise #(.DEPTH(64), .ADDR_W(11), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.ena = 1'b0; bus.dmr = 1'b0; bus.dmw = 1'b0;
        bus.dm_type = 3'b000; bus.dm_addr = '0; bus.dm_wdata = '0;
    endtask

    // Drive one request for a single rising edge; returns at edge + 1.
    task automatic do_req(input logic r, input logic w, input logic [2:0] t,
                          input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.ena = 1'b1; bus.dmr = r; bus.dmw = w;
        bus.dm_type = t; bus.dm_addr = a; bus.dm_wdata = d;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_bus();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_busy",   32'(bus.busy), 32'd1);
        chk("rst_rdata",  bus.dm_rdata, 32'h0);
        chk("rst_rvalid", 32'(bus.rdata_valid), 32'd0);
        chk("rst_ealign", 32'(bus.err_align), 32'd0);
        chk("rst_erange", 32'(bus.err_range), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("fill_cycles", 32'(cyc), 32'd64);

        do_req(1'b1, 1'b0, 3'b000, 11'd252, 32'h0);
        chk("lw63_valid", 32'(bus.rdata_valid), 32'd1);
        chk("lw63_data",  bus.dm_rdata, 32'h0);
        @(posedge clk); #1;
        chk("valid_pulse", 32'(bus.rdata_valid), 32'd0);

        do_req(1'b0, 1'b1, 3'b000, 11'h010, 32'h11223344);
        chk("sw_novalid", 32'(bus.rdata_valid), 32'd0);
        do_req(1'b0, 1'b1, 3'b011, 11'h012, 32'h000000AA);
        do_req(1'b1, 1'b0, 3'b000, 11'h010, 32'h0);
        chk("lw_merged", bus.dm_rdata, 32'h11AA3344);
        do_req(1'b1, 1'b0, 3'b011, 11'h012, 32'h0);
        chk("lb_12", bus.dm_rdata, 32'hFFFFFFAA);
        do_req(1'b1, 1'b0, 3'b100, 11'h012, 32'h0);
        chk("lbu_12", bus.dm_rdata, 32'h000000AA);
        do_req(1'b1, 1'b0, 3'b100, 11'h011, 32'h0);
        chk("lbu_11", bus.dm_rdata, 32'h00000033);

        do_req(1'b0, 1'b1, 3'b001, 11'h016, 32'hFFFF8001);
        do_req(1'b1, 1'b0, 3'b001, 11'h016, 32'h0);
        chk("lh_16", bus.dm_rdata, 32'hFFFF8001);
        do_req(1'b1, 1'b0, 3'b010, 11'h016, 32'h0);
        chk("lhu_16", bus.dm_rdata, 32'h00008001);
        do_req(1'b1, 1'b0, 3'b000, 11'h014, 32'h0);
        chk("lw_14", bus.dm_rdata, 32'h80010000);
        do_req(1'b1, 1'b0, 3'b010, 11'h014, 32'h0);
        chk("lhu_14", bus.dm_rdata, 32'h00000000);

        do_req(1'b0, 1'b1, 3'b000, 11'h020, 32'hCAFEBABE);
        do_req(1'b1, 1'b0, 3'b000, 11'h021, 32'h0);
        chk("lw21_ealign", 32'(bus.err_align), 32'd1);
        chk("lw21_erange", 32'(bus.err_range), 32'd0);
        chk("lw21_valid",  32'(bus.rdata_valid), 32'd1);
        chk("lw21_data",   bus.dm_rdata, 32'h0);
        do_req(1'b0, 1'b1, 3'b001, 11'h023, 32'h00001234);
        chk("sh23_ealign", 32'(bus.err_align), 32'd1);
        do_req(1'b1, 1'b0, 3'b000, 11'h020, 32'h0);
        chk("lw20_data",   bus.dm_rdata, 32'hCAFEBABE);
        chk("lw20_ealign", 32'(bus.err_align), 32'd0);
        do_req(1'b0, 1'b1, 3'b000, 11'h100, 32'hDEADBEEF);
        chk("sw100_erange", 32'(bus.err_range), 32'd1);
        chk("sw100_ealign", 32'(bus.err_align), 32'd0);
        do_req(1'b1, 1'b0, 3'b000, 11'h000, 32'h0);
        chk("lw0_nowrite", bus.dm_rdata, 32'h0);
        chk("lw0_noerr",   32'(bus.err_range), 32'd0);
        do_req(1'b1, 1'b0, 3'b101, 11'h010, 32'h0);
        chk("type101_ealign", 32'(bus.err_align), 32'd1);
        chk("type101_data",   bus.dm_rdata, 32'h0);
        do_req(1'b1, 1'b0, 3'b000, 11'h101, 32'h0);
        chk("both_ealign", 32'(bus.err_align), 32'd1);
        chk("both_erange", 32'(bus.err_range), 32'd1);

        do_req(1'b0, 1'b1, 3'b000, 11'h008, 32'h00000005);
        do_req(1'b1, 1'b1, 3'b000, 11'h008, 32'h00000009);
        chk("rbw_old", bus.dm_rdata, 32'h00000005);
        do_req(1'b1, 1'b0, 3'b000, 11'h008, 32'h0);
        chk("rbw_new", bus.dm_rdata, 32'h00000009);
        @(negedge clk);
        bus.dmr = 1'b1; bus.ena = 1'b0; bus.dm_addr = 11'h010;
        @(posedge clk); #1;
        idle_bus();
        chk("ena0_novalid", 32'(bus.rdata_valid), 32'd0);
        chk("rdata_hold",   bus.dm_rdata, 32'h00000009);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (bus.busy && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        chk("midfill_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 3) begin
                bus.ena = 1'b1; bus.dmw = 1'b1; bus.dmr = 1'b1;
                bus.dm_type = 3'b000; bus.dm_addr = 11'h000; bus.dm_wdata = 32'h12345678;
            end else if (cyc == 4) begin
                idle_bus();
                chk("busy_novalid", 32'(bus.rdata_valid), 32'd0);
                chk("busy_noerr",   32'(bus.err_align | bus.err_range), 32'd0);
            end
        end
        chk("refill_cycles", 32'(cyc), 32'd64);
        do_req(1'b1, 1'b0, 3'b000, 11'h000, 32'h0);
        chk("busy_write_ignored", bus.dm_rdata, 32'h0);
        do_req(1'b1, 1'b0, 3'b000, 11'h010, 32'h0);
        chk("refill_cleared", bus.dm_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
